// File: rtl/text_mode_gen.sv
// Character-cell text generator: turns DE/HS/VS timing into RGB using an
// external char/attr RAM and font ROM, with palette, cursor and blink.
module text_mode_gen #(
    parameter int   COLS         = 80,
    parameter int   ROWS         = 30,
    parameter int   CHAR_H       = 16,
    parameter int   SCALE_LOG2   = 1,
    parameter int   ADDR_W       = 12,
    parameter int   RAM_LAT      = 1,
    parameter int   FONT_LAT     = 1,
    parameter int   BLINK_FRAMES = 16,
    parameter logic VS_POL       = 1'b1,
    localparam int  GROW_W       = $clog2(CHAR_H)
) (
    input  logic                  I_pxl_clk,
    input  logic                  I_rst_n,
    input  logic                  I_de,
    input  logic                  I_hs,
    input  logic                  I_vs,
    input  logic                  I_blink_mode,
    input  logic                  I_cursor_en,
    input  logic [6:0]            I_cursor_col,
    input  logic [5:0]            I_cursor_row,
    output logic [ADDR_W-1:0]     O_char_addr,
    input  logic [7:0]            I_char_data,
    input  logic [7:0]            I_attr_data,
    output logic [8+GROW_W-1:0]   O_font_addr,
    input  logic [7:0]            I_font_data,
    output logic                  O_de,
    output logic                  O_hs,
    output logic                  O_vs,
    output logic [7:0]            O_r,
    output logic [7:0]            O_g,
    output logic [7:0]            O_b
);

    // Counters are one bit wider than the visible grid so a saturated value
    // always lands outside it (border) instead of wrapping back into text.
    localparam int PX_W  = $clog2((COLS * 8) << SCALE_LOG2) + 1;
    localparam int PY_W  = $clog2((ROWS * CHAR_H) << SCALE_LOG2) + 1;
    localparam int GX_W  = PX_W - SCALE_LOG2;
    localparam int GY_W  = PY_W - SCALE_LOG2;
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam int L     = 3 + RAM_LAT + FONT_LAT;

    typedef struct packed {
        logic              de;
        logic              in_grid;
        logic [2:0]        bt;
        logic [GROW_W-1:0] grow;
        logic              hit;
        logic              phase;
        logic              bmode;
    } side_t;

    typedef struct packed {
        logic       de;
        logic       in_grid;
        logic [2:0] bt;
        logic       hide;
        logic       hit;
        logic [3:0] fg;
        logic [3:0] bg;
    } glyph_t;

    logic [PX_W-1:0]  px_q, px_d;
    logic [PY_W-1:0]  py_q, py_d;
    logic             de_prev_q, vs_prev_q, vs_start;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;

    logic [GX_W-1:0]          gx;
    logic [GY_W-1:0]          gy;
    logic [GX_W-4:0]          col;
    logic [2:0]               bt;
    logic [GY_W-GROW_W-1:0]   row;
    logic [GROW_W-1:0]        grow;
    logic                     in_grid, hit;
    logic [ADDR_W-1:0]        addr_d;

    side_t  [RAM_LAT:0]  side_q;
    glyph_t [FONT_LAT:0] gly_q;
    glyph_t              gly_d, gs;
    logic [L-1:0][2:0]   tim_q;

    logic       pix;
    logic [3:0] idx;
    logic [7:0] hi, r_d, g_d, b_d;

    assign vs_start = (I_vs == VS_POL) && (vs_prev_q != VS_POL);

    // Position counters and frame-based blink timer; VS clear beats the DE-fall increment
    always_comb begin
        px_d = '0;
        if (I_de) px_d = (&px_q) ? px_q : px_q + 1'b1;
        py_d = py_q;
        if (vs_start)                                 py_d = '0;
        else if (de_prev_q && !I_de && !(&py_q))      py_d = py_q + 1'b1;
        blk_cnt_d = blk_cnt_q;
        phase_d   = phase_q;
        if (vs_start) begin
            if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blk_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
    end

    // Grid coordinates, cell address and cursor hit for the incoming pixel
    always_comb begin
        gx      = px_q[PX_W-1:SCALE_LOG2];
        gy      = py_q[PY_W-1:SCALE_LOG2];
        col     = gx[GX_W-1:3];
        bt      = gx[2:0];
        row     = gy[GY_W-1:GROW_W];
        grow    = gy[GROW_W-1:0];
        in_grid = (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
        hit     = I_cursor_en && (32'(col) == 32'(I_cursor_col)) &&
                  (32'(row) == 32'(I_cursor_row)) &&
                  (32'(grow) >= 32'(CHAR_H - 2)) && phase_q;
        addr_d  = in_grid ? ADDR_W'(32'(row) * 32'(COLS) + 32'(col)) : '0;
    end

    // Attribute decode once char/attr data is back from RAM
    always_comb begin
        gly_d         = '0;
        gly_d.de      = side_q[RAM_LAT].de;
        gly_d.in_grid = side_q[RAM_LAT].in_grid;
        gly_d.bt      = side_q[RAM_LAT].bt;
        gly_d.hit     = side_q[RAM_LAT].hit;
        gly_d.fg      = I_attr_data[3:0];
        gly_d.bg      = side_q[RAM_LAT].bmode ? {1'b0, I_attr_data[6:4]} : I_attr_data[7:4];
        gly_d.hide    = side_q[RAM_LAT].bmode && I_attr_data[7] && side_q[RAM_LAT].phase;
    end

    // Glyph pixel select, blink/cursor, palette lookup and border blanking
    always_comb begin
        gs  = gly_q[FONT_LAT];
        pix = I_font_data[3'd7 - gs.bt];
        if (gs.hide) pix = 1'b0;
        if (gs.hit)  pix = ~pix;
        idx = pix ? gs.fg : gs.bg;
        hi  = idx[3] ? 8'h55 : 8'h00;
        r_d = (idx[2] ? 8'hAA : 8'h00) + hi;
        g_d = (idx[1] ? 8'hAA : 8'h00) + hi;
        b_d = (idx[0] ? 8'hAA : 8'h00) + hi;
        if (idx == 4'd6) g_d = 8'h55;
        if (!(gs.de && gs.in_grid)) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    // Counter, edge-detect and blink state registers
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            px_q      <= '0;
            py_q      <= '0;
            de_prev_q <= 1'b0;
            vs_prev_q <= VS_POL;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            px_q      <= px_d;
            py_q      <= py_d;
            de_prev_q <= I_de;
            vs_prev_q <= I_vs;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Fetch pipeline: side info rides alongside the RAM and ROM reads
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_char_addr <= '0;
            O_font_addr <= '0;
            side_q      <= '0;
            gly_q       <= '0;
        end else begin
            O_char_addr <= addr_d;
            side_q[0]   <= {I_de, in_grid, bt, grow, hit, phase_q, I_blink_mode};
            for (int i = 1; i <= RAM_LAT; i++) side_q[i] <= side_q[i-1];
            O_font_addr <= {I_char_data, side_q[RAM_LAT].grow};
            gly_q[0]    <= gly_d;
            for (int i = 1; i <= FONT_LAT; i++) gly_q[i] <= gly_q[i-1];
        end
    end

    // Output colour and timing delayed by the full pipeline depth
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_r   <= '0;
            O_g   <= '0;
            O_b   <= '0;
            tim_q <= '0;
        end else begin
            O_r   <= r_d;
            O_g   <= g_d;
            O_b   <= b_d;
            tim_q <= {tim_q[L-2:0], {I_de, I_hs, I_vs}};
        end
    end

    assign {O_de, O_hs, O_vs} = tim_q[L-1];

endmodule
